// File: rtl/dma_sdram_read_channel.sv
// rtl/dma_sdram_read_channel.sv - single-beat wishbone DMA read channel into the SDRAM window with a stream-out FIFO
module dma_sdram_read_channel #(
  parameter int          FIFO_DEPTH = 8,
  parameter int          LEN_W      = 16,
  parameter logic [8:0]  DMA_REGION = 9'hF0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_start,
  input  logic [22:0]      cfg_src,
  input  logic [LEN_W-1:0] cfg_len,
  output logic             busy,
  output logic             done,
  output logic             m_cyc_o,
  output logic             m_stb_o,
  output logic             m_we_o,
  output logic [31:0]      m_adr_o,
  input  logic [31:0]      m_dat_i,
  input  logic             m_ack_i,
  input  logic             m_burst_i,
  output logic [31:0]      s_data,
  output logic             s_valid,
  input  logic             s_ready,
  output logic [LEN_W-1:0] burst_hits
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, REQ, DRAIN, FIN} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [20:0]        r_offset;
  logic [LEN_W-1:0]   r_issue;
  logic [LEN_W-1:0]   r_drain;
  logic [LEN_W-1:0]   r_hits;
  logic               r_stb;
  logic [31:0]        r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wr;
  logic [PTR_W-1:0]   r_rd;
  logic [PTR_W:0]     r_count;

  logic w_accept, w_ack, w_pop, w_last, w_room, w_busy, w_done;
  logic w_unused_src;

  assign w_unused_src = |cfg_src[1:0];
  assign w_accept     = (r_state == IDLE) && cfg_start;
  assign w_ack        = r_stb && m_ack_i;
  assign w_pop        = (r_count != '0) && s_ready;
  assign w_last       = w_ack && (r_issue == LEN_W'(1));
  // Pops in flight are treated as still occupied, so only the registered count gates a request.
  assign w_room       = r_count < (PTR_W+1)'(FIFO_DEPTH);

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      IDLE:  if (cfg_start) w_next = (cfg_len == '0) ? FIN : REQ;
      REQ: begin
        w_busy = 1'b1;
        if (w_last) w_next = DRAIN;
      end
      DRAIN: begin
        w_busy = 1'b1;
        if (r_drain == '0) w_next = FIN;
      end
      FIN: begin
        w_done = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_offset <= '0;
      r_issue  <= '0;
      r_drain  <= '0;
      r_hits   <= '0;
      r_stb    <= 1'b0;
      r_wr     <= '0;
      r_rd     <= '0;
      r_count  <= '0;
    end else begin
      if (w_accept) begin
        r_offset <= cfg_src[22:2];
        r_issue  <= cfg_len;
        r_drain  <= cfg_len;
        r_hits   <= '0;
      end
      // stb is only raised from a low state, which enforces the one-cycle gap between beats.
      if (w_ack)
        r_stb <= 1'b0;
      else if ((r_state == REQ) && !r_stb && (r_issue != '0) && w_room)
        r_stb <= 1'b1;
      if (w_ack) begin
        r_offset <= r_offset + 21'd1;
        r_issue  <= r_issue - 1'b1;
        r_wr     <= r_wr + 1'b1;
        if (m_burst_i && (r_hits != '1)) r_hits <= r_hits + 1'b1;
      end
      if (w_pop) begin
        r_rd    <= r_rd + 1'b1;
        r_drain <= r_drain - 1'b1;
      end
      case ({w_ack, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_ack) r_mem[r_wr] <= m_dat_i;
  end

  assign busy       = w_busy;
  assign done       = w_done;
  assign m_cyc_o    = r_stb;
  assign m_stb_o    = r_stb;
  assign m_we_o     = 1'b0;
  assign m_adr_o    = r_stb ? {DMA_REGION, r_offset, 2'b00} : 32'h0;
  assign s_data     = r_mem[r_rd];
  assign s_valid    = (r_count != '0);
  assign burst_hits = r_hits;
endmodule

// File: tb/tb_dma_sdram_read_channel.sv
// tb/tb_dma_sdram_read_channel.sv - randomized bench for dma_sdram_read_channel against a queue-based reference
module tb_dma_sdram_read_channel;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_start = 1'b0;
  logic [22:0] cfg_src = '0;
  logic [15:0] cfg_len = '0;
  logic        busy, done, m_cyc_o, m_stb_o, m_we_o;
  logic [31:0] m_adr_o;
  logic [31:0] m_dat_i = '0;
  logic        m_ack_i = 1'b0;
  logic        m_burst_i = 1'b0;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready = 1'b0;
  logic [15:0] burst_hits;

  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  dma_sdram_read_channel #(.FIFO_DEPTH(DEPTH), .LEN_W(16), .DMA_REGION(9'hF0)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_src(cfg_src), .cfg_len(cfg_len),
    .busy(busy), .done(done), .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o),
    .m_adr_o(m_adr_o), .m_dat_i(m_dat_i), .m_ack_i(m_ack_i), .m_burst_i(m_burst_i),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .burst_hits(burst_hits)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] beat_adr(input logic [22:0] src, input int i);
    logic [22:0] off;
    off = {src[22:2], 2'b00} + 23'(4 * i);
    return {9'hF0, off};
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] adr);
    return (adr * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  // rmode: 0 always ready, 1 random, 2 held low until cycle rhold. dly<0 picks a random ack delay per beat.
  task automatic run_job(input logic [22:0] src, input int len, input int dly, input int rmode,
                         input int rhold, input logic [31:0] bmask, input bit spur,
                         input int restart_at, input int rst_beat);
    int beats = 0, pops = 0, occ = 0, wait_c = 0, cyc = 0, stb_cyc = 0;
    int done_cnt = 0, done_cyc = -1, exp_hits = 0, cur_dly;
    bit prev_ack = 0, acked, seen = 0, fin = 0, ready;
    logic [31:0] exp_q[$];
    for (int i = 0; i < len; i++) begin
      exp_q.push_back(word_at(beat_adr(src, i)));
      if (i < 32 && bmask[i]) exp_hits++;
    end
    cur_dly = (dly < 0) ? int'($urandom_range(0, 3)) : dly;
    @(negedge clk);
    cfg_src = src;
    cfg_len = 16'(len);
    cfg_start = 1'b1;
    while (!fin && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      cfg_start = 1'b0;
      if (restart_at != 0 && cyc == restart_at && busy && done_cnt == 0) begin
        cfg_start = 1'b1;
        cfg_src = 23'($urandom);
        cfg_len = 16'd3;
      end
      m_ack_i = 1'b0;
      m_burst_i = spur ? 1'($urandom_range(0, 1)) : 1'b0;
      acked = 0;
      check("s_valid", 32'(s_valid), 32'(occ > 0));
      if (done) begin
        done_cnt++;
        if (done_cnt == 1) begin
          done_cyc = cyc;
          check("pops_at_done", pops, len);
          check("burst_hits", 32'(burst_hits), exp_hits);
        end
      end
      if (m_stb_o) begin
        stb_cyc++;
        check("stb_gap", 32'(prev_ack), 0);
        if (!seen) begin
          seen = 1;
          wait_c = 0;
          check("adr", m_adr_o, beat_adr(src, beats));
          check("beat_in_range", 32'(beats < len), 1);
          check("fifo_room", 32'(occ < DEPTH), 1);
          check("cyc_we", {30'b0, m_cyc_o, m_we_o}, 2);
          if (beats == rst_beat) begin
            rst_n = 1'b0;
            @(negedge clk);
            check("rst_cyc", 32'(m_cyc_o), 0);
            check("rst_valid", 32'(s_valid), 0);
            check("rst_busy", 32'(busy), 0);
            rst_n = 1'b1;
            return;
          end
        end
        if (wait_c == cur_dly) begin
          m_ack_i = 1'b1;
          m_dat_i = word_at(beat_adr(src, beats));
          m_burst_i = (beats < 32) ? bmask[beats] : 1'b0;
          beats++;
          occ++;
          seen = 0;
          acked = 1;
          cur_dly = (dly < 0) ? int'($urandom_range(0, 3)) : dly;
        end else begin
          wait_c++;
        end
      end else if (spur && $urandom_range(0, 3) == 0) begin
        m_ack_i = 1'b1;
        m_dat_i = $urandom;
      end
      prev_ack = acked;
      case (rmode)
        0:       ready = 1;
        1:       ready = 1'($urandom_range(0, 1));
        default: ready = (cyc >= rhold);
      endcase
      s_ready = ready;
      if (rmode == 2 && cyc == rhold) check("acks_while_stalled", beats, DEPTH);
      if (s_valid && ready) begin
        check("pop_in_range", 32'(pops < len), 1);
        if (pops < len) check("data", s_data, exp_q[pops]);
        pops++;
        occ--;
      end
      if (done_cnt > 0 && cyc >= done_cyc + 3) fin = 1;
    end
    m_ack_i = 1'b0;
    s_ready = 1'b0;
    check("job_finished", 32'(fin), 1);
    check("done_once", done_cnt, 1);
    check("busy_after", 32'(busy), 0);
    if (len == 0) begin
      check("len0_no_stb", stb_cyc, 0);
      check("len0_done_fast", 32'(done_cyc >= 1 && done_cyc <= 2), 1);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy0", 32'(busy), 0);
    check("rst_done0", 32'(done), 0);
    check("rst_bus0", {29'b0, m_cyc_o, m_stb_o, m_we_o}, 0);
    check("rst_valid0", 32'(s_valid), 0);
    check("rst_adr0", m_adr_o, 0);
    check("rst_hits0", 32'(burst_hits), 0);
    rst_n = 1'b1;
    @(negedge clk);
    run_job(23'h000100, 4, 2, 0, 0, 32'h0, 0, 0, -1);
    run_job(23'h001000, 0, 2, 0, 0, 32'h0, 0, 0, -1);
    run_job(23'h000400, 12, 0, 2, 40, 32'h0, 0, 0, -1);
    run_job(23'h7FFFF8, 3, 1, 0, 0, 32'h0, 0, 0, -1);
    run_job(23'h002000, 6, 1, 0, 0, 32'h0, 0, 0, 2);
    run_job(23'h003000, 6, 1, 1, 0, 32'h0, 0, 0, -1);
    run_job(23'h000200, 5, -1, 1, 0, 32'h6, 0, 4, -1);
    for (int j = 0; j < 12; j++)
      run_job(23'($urandom), int'($urandom_range(1, 20)), -1, 1, 0, $urandom, 1,
              int'($urandom_range(1, 30)), -1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
